// File: rtl/rggen_bus_arbiter_pkg.sv
// Shared definitions for the rggen native-bus round-robin arbiter:
// bus access codes, response status codes and arbiter FSM states.
package rggen_bus_arbiter_pkg;

  // rggen native bus access codes
  localparam logic [1:0] RGGEN_READ  = 2'b10;
  localparam logic [1:0] RGGEN_WRITE = 2'b11;

  // rggen native bus status codes
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  // Arbiter FSM states; RESP is only reachable with the registered response path
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } arb_state_e;

endpackage

// File: rtl/rggen_rr_arbiter.sv
// Combinational round-robin picker: the requester right after i_last has
// highest priority, wrapping modulo N_REQ. Reusable wherever a last-grant
// index is kept by the caller.
module rggen_rr_arbiter #(
  parameter int N_REQ     = 2,
  parameter int IDX_WIDTH = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0]     i_request,
  input  logic [IDX_WIDTH-1:0] i_last,
  output logic                 o_any,
  output logic [IDX_WIDTH-1:0] o_grant_idx
);

  logic [2*N_REQ-1:0] doubled;
  logic [2*N_REQ-1:0] shifted;
  logic [N_REQ-1:0]   rotated;
  int unsigned        pos;
  int unsigned        idx;

  // Rotate so slot i_last+1 lands on bit 0, take the lowest set bit, rotate the index back
  always_comb begin
    doubled = {i_request, i_request};
    shifted = doubled >> (32'(i_last) + 32'd1);
    rotated = shifted[N_REQ-1:0];
    pos     = 0;
    for (int unsigned i = N_REQ; i > 0; i--) begin
      if (rotated[i-1]) pos = i - 1;
    end
    idx         = (32'(i_last) + 32'd1 + pos) % N_REQ;
    o_grant_idx = IDX_WIDTH'(idx);
    o_any       = |i_request;
  end

endmodule

// File: rtl/rggen_bus_arbiter.sv
// Round-robin arbiter sharing one rggen native bus master port between
// N_REQ requesters. One whole transaction is granted at a time; the
// response goes back only to the granted requester.
// Optional: define RGGEN_BUS_ARBITER_RESPONSE_REG_EN to register the
// response (ready/status/read data) one cycle after i_bus_ready.
module rggen_bus_arbiter
  import rggen_bus_arbiter_pkg::*;
#(
  parameter int N_REQ         = 2,
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32,
  // derived; leave at default
  parameter int IDX_WIDTH     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [N_REQ-1:0]               i_req_valid,
  input  logic [2*N_REQ-1:0]             i_req_access,
  input  logic [ADDRESS_WIDTH*N_REQ-1:0] i_req_address,
  input  logic [BUS_WIDTH*N_REQ-1:0]     i_req_write_data,
  input  logic [(BUS_WIDTH/8)*N_REQ-1:0] i_req_strobe,
  output logic [N_REQ-1:0]               o_req_ready,
  output logic [1:0]                     o_req_status,
  output logic [BUS_WIDTH-1:0]           o_req_read_data,
  output logic                           o_bus_valid,
  output logic [1:0]                     o_bus_access,
  output logic [ADDRESS_WIDTH-1:0]       o_bus_address,
  output logic [BUS_WIDTH-1:0]           o_bus_write_data,
  output logic [BUS_WIDTH/8-1:0]         o_bus_strobe,
  input  logic                           i_bus_ready,
  input  logic [1:0]                     i_bus_status,
  input  logic [BUS_WIDTH-1:0]           i_bus_read_data,
  output logic [IDX_WIDTH-1:0]           o_grant_idx,
  output logic                           o_busy
);

  localparam int STRB_WIDTH = BUS_WIDTH / 8;

  arb_state_e             r_state;
  logic [IDX_WIDTH-1:0]   r_grant;
  logic [IDX_WIDTH-1:0]   r_last;
  logic                   r_bus_valid;
  logic                   r_busy;
  logic                   any_req;
  logic [IDX_WIDTH-1:0]   win_idx;
  logic [N_REQ-1:0]       grant_onehot;
`ifdef RGGEN_BUS_ARBITER_RESPONSE_REG_EN
  logic [N_REQ-1:0]       r_resp_ready;
  logic [1:0]             r_resp_status;
  logic [BUS_WIDTH-1:0]   r_resp_data;
`endif

  rggen_rr_arbiter #(
    .N_REQ     (N_REQ),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_rr_arbiter (
    .i_request   (i_req_valid),
    .i_last      (r_last),
    .o_any       (any_req),
    .o_grant_idx (win_idx)
  );

  // Decode the grant to one-hot and mux the granted requester's fields downstream
  always_comb begin
    grant_onehot     = '0;
    o_bus_access     = i_req_access[1:0];
    o_bus_address    = i_req_address[ADDRESS_WIDTH-1:0];
    o_bus_write_data = i_req_write_data[BUS_WIDTH-1:0];
    o_bus_strobe     = i_req_strobe[STRB_WIDTH-1:0];
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (r_grant == IDX_WIDTH'(k)) begin
        grant_onehot[k]  = 1'b1;
        o_bus_access     = i_req_access[2*k +: 2];
        o_bus_address    = i_req_address[ADDRESS_WIDTH*k +: ADDRESS_WIDTH];
        o_bus_write_data = i_req_write_data[BUS_WIDTH*k +: BUS_WIDTH];
        o_bus_strobe     = i_req_strobe[STRB_WIDTH*k +: STRB_WIDTH];
      end
    end
  end

  // Grant/transaction FSM; downstream valid and busy are registered with the state
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_last      <= IDX_WIDTH'(N_REQ - 1);
      r_bus_valid <= 1'b0;
      r_busy      <= 1'b0;
`ifdef RGGEN_BUS_ARBITER_RESPONSE_REG_EN
      r_resp_ready  <= '0;
      r_resp_status <= '0;
      r_resp_data   <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (any_req) begin
            r_grant     <= win_idx;
            r_state     <= BUSY;
            r_bus_valid <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        BUSY: begin
          if (i_bus_ready) begin
            r_last      <= r_grant;
            r_bus_valid <= 1'b0;
`ifdef RGGEN_BUS_ARBITER_RESPONSE_REG_EN
            r_state       <= RESP;
            r_resp_ready  <= grant_onehot;
            r_resp_status <= i_bus_status;
            r_resp_data   <= i_bus_read_data;
`else
            r_state     <= IDLE;
            r_busy      <= 1'b0;
`endif
          end
        end
`ifdef RGGEN_BUS_ARBITER_RESPONSE_REG_EN
        RESP: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
`endif
        default: begin
          r_state     <= IDLE;
          r_bus_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  // Route the completion back to the granted requester only
  always_comb begin
    o_req_ready     = '0;
    o_req_status    = OKAY;
    o_req_read_data = i_bus_read_data;
`ifdef RGGEN_BUS_ARBITER_RESPONSE_REG_EN
    if (r_state == RESP) begin
      o_req_ready     = r_resp_ready;
      o_req_status    = r_resp_status;
      o_req_read_data = r_resp_data;
    end
`else
    if ((r_state == BUSY) && i_bus_ready) begin
      o_req_ready  = grant_onehot;
      o_req_status = i_bus_status;
    end
`endif
  end

  assign o_bus_valid = r_bus_valid;
  assign o_busy      = r_busy;
  assign o_grant_idx = r_grant;

endmodule

// File: doc/rggen_bus_arbiter.md
Name: rggen_bus_arbiter

Overview:
- Round-robin arbiter that shares one rggen native bus master port between N_REQ requesters, e.g. host SPI bridge and on-chip sequencer.
- Its downstream port drives the rggen bus input of the AXI4-Lite bridge or a register block directly.
- Grants one full transaction at a time and returns ready/status/read data only to the granted requester.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- ADDRESS_WIDTH, 8, bus address width.
- BUS_WIDTH, 32, data width; strobe width is BUS_WIDTH/8.
- IDX_WIDTH, (N_REQ>1)?$clog2(N_REQ):1, grant index width (derived, not overridden).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_req_valid  in  N_REQ  per-requester bus valid.
- i_req_access  in  2*N_REQ  per-requester access code; slice k = [2k+1:2k].
- i_req_address  in  ADDRESS_WIDTH*N_REQ  per-requester address.
- i_req_write_data  in  BUS_WIDTH*N_REQ  per-requester write data.
- i_req_strobe  in  (BUS_WIDTH/8)*N_REQ  per-requester byte strobe.
- o_req_ready  out  N_REQ  one-hot completion pulse.
- o_req_status  out  2  status for the completing requester.
- o_req_read_data  out  BUS_WIDTH  read data for the completing requester.
- o_bus_valid  out  1  downstream valid.
- o_bus_access  out  2  downstream access code.
- o_bus_address  out  ADDRESS_WIDTH  downstream address.
- o_bus_write_data  out  BUS_WIDTH  downstream write data.
- o_bus_strobe  out  BUS_WIDTH/8  downstream strobe.
- i_bus_ready  in  1  downstream completion.
- i_bus_status  in  2  downstream status.
- i_bus_read_data  in  BUS_WIDTH  downstream read data.
- o_grant_idx  out  IDX_WIDTH  current or last grant index (debug).
- o_busy  out  1  high while a transaction is outstanding.

Behaviour:
- One clock domain: i_clk. Reset i_rst is asynchronous, active-high.
- Reset values:
  - state = IDLE, r_grant = 0, r_last = N_REQ-1 (so requester 0 has first priority).
  - o_bus_valid = 0, o_req_ready = 0, o_busy = 0.
- Requester protocol:
  - A requester holds valid and all request fields stable from assertion until it sees its o_req_ready bit.
  - The arbiter does not sample request fields; it muxes them live from the granted slice.
- IDLE:
  - If any i_req_valid is set, pick the first set bit scanning r_last+1, r_last+2, ... (mod N_REQ).
  - Register the winner into r_grant and go to BUSY.
  - No valid: stay in IDLE.
- BUSY:
  - o_bus_valid = 1. o_bus_* = slice r_grant. o_busy = 1.
  - When i_bus_ready = 1, combinationally:
    - o_req_ready[r_grant] = 1;
    - o_req_status = i_bus_status;
    - o_req_read_data = i_bus_read_data.
  - On that edge: r_last <= r_grant, state <= IDLE.
- Latency:
  - Request to o_bus_valid: 1 cycle.
  - Minimum 1 idle cycle between consecutive grants, so ready can never reach a new grant in its grant cycle.
- Outside BUSY:
  - o_bus_valid = 0. o_req_ready = 0.
  - o_bus_* data fields = slice r_grant (don't-care to downstream).
  - o_req_status = 2'b00. o_req_read_data = i_bus_read_data.
- Simultaneous requests: strict round-robin, so no requester waits more than N_REQ-1 transactions.
- i_bus_ready while IDLE is ignored.
- Granted requester drops valid mid-transaction: protocol violation. The grant and o_bus_valid are held until i_bus_ready; no abort.
- Reset mid-transaction: immediate return to IDLE, all outputs to reset values. Downstream must share the same reset.

Optional Feature:
- Macro: RGGEN_BUS_ARBITER_RESPONSE_REG_EN.
- Defined:
  - Adds state RESP. On i_bus_ready in BUSY, register status, read data and a one-hot ready, then go to RESP.
  - In RESP: o_req_ready/status/read_data come from the registers (one cycle later); o_bus_valid = 0; next cycle IDLE.
  - Breaks the combinational path from i_bus_ready to the requester.
- Undefined: combinational response path as described above.

Decomposition:
- Shared package rggen_bus_arbiter_pkg:
  - access codes RGGEN_READ = 2'b10, RGGEN_WRITE = 2'b11;
  - status codes OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11;
  - state encodings IDLE / BUSY / RESP.
- Sub-module rggen_rr_arbiter:
  - inputs: request vector, last-grant index;
  - outputs: any-request flag, winning index;
  - purely combinational rotate/priority-encode/unrotate; reusable elsewhere.

Test Plan (N_REQ = 3):
- Single write: req0 write addr 0x10, data 0xA5A5_0001, strobe 0xF; downstream ready after 3 cycles with status 0 -> o_bus_valid asserted 1 cycle after req, one o_req_ready[0] pulse, status 0.
- Simultaneous: req0/1/2 all valid at reset release, reads of 0x00/0x04/0x08 -> grants 0, 1, 2 in order, each separated by 1 IDLE cycle; read data 0x11/0x22/0x33 routed to the matching requester only.
- Fairness: req0 re-requests immediately after each completion, req2 constantly valid -> pattern 0, 2, 0, 2; req2 never starved.
- Error status: downstream returns 2'b10 on req1 read -> o_req_status = 2'b10 with o_req_ready[1] only; o_req_ready[0] and [2] stay 0.
- Reset: assert i_rst 2 cycles into a BUSY with req2 granted -> o_bus_valid = 0 asynchronously; after release req0 wins first.
- With RGGEN_BUS_ARBITER_RESPONSE_REG_EN: same single write -> o_req_ready arrives 1 cycle after i_bus_ready, with status/read data held in that cycle.
